// File: rtl/uart_rx_pkg.sv
// Shared state encoding and constants for the UART receive engine.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int MIN_CYCLES_PER_BIT = 4;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; a push while full is dropped unless a pop
// frees the slot in the same cycle.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: 2-flop synchroniser, 8-bit frame FSM and receive FIFO.
// Define UART_RX_PARITY_EN to add parity_mode, parity_error and the PARITY state.
module uart_rx_engine
  import uart_rx_pkg::*;
#(
  parameter int CLOCK_SCALE_WIDTH = 16,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_enable,
  input  logic [CLOCK_SCALE_WIDTH-1:0]  cycles_per_bit,
  input  logic                          uart_rx,
  output logic [7:0]                    data_out,
  output logic                          data_valid,
  input  logic                          data_read,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_error,
  output logic                          overflow,
`ifdef UART_RX_PARITY_EN
  input  logic [1:0]                    parity_mode,
  output logic                          parity_error,
`endif
  input  logic                          clear_errors
);

  localparam int            CW    = CLOCK_SCALE_WIDTH;
  localparam logic [CW-1:0] MIN_P = CW'(MIN_CYCLES_PER_BIT);

  rx_state_e     state_q, state_d;
  logic          sync1_q, sync1_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
  logic [CW-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_error_q, frame_error_d, overflow_q, overflow_d;
  logic          push, frame_set, fifo_full, fifo_empty, rxs_fall, bit_end;

`ifdef UART_RX_PARITY_EN
  logic parity_error_q, parity_error_d, parity_bad_q, parity_bad_d;
  logic parity_set, parity_on, parity_exp;

  assign parity_on    = (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD);
  assign parity_exp   = (^shift_q) ^ (parity_mode == PARITY_ODD);
  assign parity_error = parity_error_q;
`endif

  assign sync1_d    = uart_rx;
  assign rxs_d      = sync1_q;
  assign rxs_prev_d = rxs_q;
  assign rxs_fall   = rxs_prev_q & ~rxs_q;
  assign bit_end    = (cnt_q == period_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    period_d  = period_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_set   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxs_fall) begin
          state_d  = START;
          period_d = (cycles_per_bit < MIN_P) ? MIN_P : cycles_per_bit;
        end
      end
      START: begin
        if (cnt_q == (period_q >> 1)) begin
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            parity_bad_d = 1'b0;
`endif
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rxs_q;
          bit_idx_d          = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = parity_on ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
          if (rxs_q != parity_exp) begin
            parity_set   = 1'b1;
            parity_bad_d = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
            push = !parity_bad_q;
`else
            push = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      // A held-low line must return high before another start bit is accepted.
      BREAK: begin
        cnt_d = '0;
        if (rxs_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rx_enable) begin
      state_d   = IDLE;
      push      = 1'b0;
      frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_set = 1'b0;
`endif
    end
  end

  // Set events win over a simultaneous clear.
  assign frame_error_d = (frame_error_q & ~clear_errors) | frame_set;
  assign overflow_d    = (overflow_q & ~clear_errors) | (push & fifo_full & ~data_read);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b1;
      rxs_q         <= 1'b1;
      rxs_prev_q    <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      period_q      <= MIN_P;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      rxs_q         <= rxs_d;
      rxs_prev_q    <= rxs_prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      frame_error_q <= frame_error_d;
      overflow_q    <= overflow_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_error_d = (parity_error_q & ~clear_errors) | parity_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_error_q <= 1'b0;
      parity_bad_q   <= 1'b0;
    end else begin
      parity_error_q <= parity_error_d;
      parity_bad_q   <= parity_bad_d;
    end
  end
`endif

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_q),
    .pop       (data_read),
    .head      (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign data_valid  = ~fifo_empty;
  assign frame_error = frame_error_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: drives serial frames and compares the DUT every cycle
// against a queue model of the receive FIFO and sticky flags.
`timescale 1ns/1ps
module tb_uart_rx_engine;

  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst, rx_enable, uart_rx, clear_errors;
  logic [CW-1:0] cycles_per_bit;
  logic          data_read, data_read_man, data_read_rnd, rnd_read_en;
  logic [7:0]    data_out;
  logic          data_valid, frame_error, overflow;
  logic [3:0]    fifo_count;
`ifdef UART_RX_PARITY_EN
  logic [1:0]    parity_mode;
  logic          parity_error;
`endif

  assign data_read = data_read_man | data_read_rnd;

  always #5 clk = ~clk;

  uart_rx_engine #(
    .CLOCK_SCALE_WIDTH(CW),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_enable     (rx_enable),
    .cycles_per_bit(cycles_per_bit),
    .uart_rx       (uart_rx),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_read     (data_read),
    .fifo_count    (fifo_count),
    .frame_error   (frame_error),
    .overflow      (overflow),
`ifdef UART_RX_PARITY_EN
    .parity_mode   (parity_mode),
    .parity_error  (parity_error),
`endif
    .clear_errors  (clear_errors)
  );

  // Model: the driver schedules what each frame must produce at the clock edge
  // where the frame's decision falls; the model applies those outcomes to a queue.
  typedef enum int {EV_PUSH, EV_FERR, EV_PERR} ev_kind_e;
  typedef struct {
    int         cyc;
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  int         cyc = 0;
  bit         m_live = 1'b0;
  bit         m_ferr, m_ovf, m_perr;
  bit         ev_push, ev_ferr, ev_perr, pop_ok, o_set;
  logic [7:0] ev_data;
  int         n_checks = 0;
  int         n_fail   = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      evq.delete();
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
      m_perr = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      ev_push = 1'b0;
      ev_ferr = 1'b0;
      ev_perr = 1'b0;
      ev_data = 8'h00;
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].cyc == cyc) begin
          case (evq[i].kind)
            EV_PUSH: begin ev_push = 1'b1; ev_data = evq[i].data; end
            EV_FERR: ev_ferr = 1'b1;
            default: ev_perr = 1'b1;
          endcase
          evq.delete(i);
        end
      end
      pop_ok = data_read && (mq.size() > 0);
      o_set  = ev_push && (mq.size() == DEPTH) && !pop_ok;
      if (pop_ok) void'(mq.pop_front());
      if (ev_push && !o_set) mq.push_back(ev_data);
      m_ferr = (m_ferr && !clear_errors) || ev_ferr;
      m_ovf  = (m_ovf  && !clear_errors) || o_set;
      m_perr = (m_perr && !clear_errors) || ev_perr;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("cyc_data_valid", 32'(data_valid), 32'(mq.size() != 0));
      checkOutput("cyc_fifo_count", 32'(fifo_count), 32'(mq.size()));
      if (mq.size() != 0) checkOutput("cyc_data_out", 32'(data_out), 32'(mq[0]));
      checkOutput("cyc_frame_error", 32'(frame_error), 32'(m_ferr));
      checkOutput("cyc_overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_PARITY_EN
      checkOutput("cyc_parity_error", 32'(parity_error), 32'(m_perr));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one frame. par_bit < 0 means no parity bit; cut_bit >= 0 drops rx_enable
  // (or asserts rst) when that frame bit starts and keeps it so until the line idles.
  task automatic applyStimulus(input logic [7:0] data, input int cpb, input bit stop_bit,
                               input int par_bit, input int cut_bit, input bit cut_reset,
                               input int extra_low, input bit read_at_push);
    int          p, c0, nbits, par_edge, push_edge;
    logic [10:0] bits;
    bit          has_par, par_ok;
    p              = (cpb < 4) ? 4 : cpb;
    cycles_per_bit = CW'(cpb);
    has_par        = (par_bit >= 0);
    bits           = '1;
    bits[0]        = 1'b0;
    bits[8:1]      = data;
    nbits          = has_par ? 11 : 10;
    if (has_par) begin
      bits[9]  = par_bit[0];
      bits[10] = stop_bit;
    end else begin
      bits[9] = stop_bit;
    end
    par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (has_par)
      par_ok = ((($countones(data) + par_bit) % 2) == ((parity_mode == 2'b10) ? 1 : 0));
`endif
    c0        = cyc;
    par_edge  = c0 + 4 + p / 2 + 9 * p;
    push_edge = par_edge + (has_par ? p : 0);
    if (cut_bit < 0) begin
      if (!par_ok) evq.push_back('{par_edge, EV_PERR, data});
      if (!stop_bit) evq.push_back('{push_edge, EV_FERR, data});
      else if (par_ok) evq.push_back('{push_edge, EV_PUSH, data});
    end
    for (int k = 0; k < nbits; k++) begin
      uart_rx = bits[k];
      if (k == cut_bit) begin
        if (cut_reset) rst = 1'b1;
        else rx_enable = 1'b0;
      end
      for (int j = 0; j < p; j++) begin
        data_read_man = read_at_push && (cyc == push_edge - 1);
        step(1);
      end
    end
    data_read_man = 1'b0;
    step(extra_low);
    uart_rx = 1'b1;
    step(p + 2);
    rst       = 1'b0;
    rx_enable = 1'b1;
  endtask

  task automatic popExpect(input logic [7:0] exp, input string name);
    checkOutput({name, "_valid"}, 32'(data_valid), 32'd1);
    checkOutput(name, 32'(data_out), 32'(exp));
    data_read_man = 1'b1;
    step(1);
    data_read_man = 1'b0;
  endtask

  task automatic pulseClear();
    clear_errors = 1'b1;
    step(1);
    clear_errors = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      data_read_rnd = rnd_read_en && ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    rx_enable      = 1'b1;
    cycles_per_bit = CW'(16);
    uart_rx        = 1'b1;
    data_read_man  = 1'b0;
    data_read_rnd  = 1'b0;
    rnd_read_en    = 1'b0;
    clear_errors   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_mode    = 2'b00;
`endif
    step(3);
    rst = 1'b0;
    step(2);
    checkOutput("rst_data_valid", 32'(data_valid), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_frame_error", 32'(frame_error), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);

    $display("[TB] basic 0xA5 frame at P=16");
    applyStimulus(8'hA5, 16, 1'b1, -1, -1, 1'b0, 0, 1'b0);
    checkOutput("a5_fifo_count", 32'(fifo_count), 32'd1);
    popExpect(8'hA5, "a5_data");
    checkOutput("a5_valid_after_pop", 32'(data_valid), 32'd0);

    $display("[TB] start-bit glitch, then clamped bit period");
    uart_rx = 1'b0;
    step(5);
    uart_rx = 1'b1;
    step(40);
    checkOutput("glitch_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("glitch_frame_error", 32'(frame_error), 32'd0);
    applyStimulus(8'h3C, 2, 1'b1, -1, -1, 1'b0, 0, 1'b0);
    popExpect(8'h3C, "clamp_data");

    $display("[TB] framing error with held-low line");
    applyStimulus(8'h3C, 16, 1'b0, -1, -1, 1'b0, 40, 1'b0);
    checkOutput("ferr_frame_error", 32'(frame_error), 32'd1);
    checkOutput("ferr_fifo_count", 32'(fifo_count), 32'd0);
    pulseClear();
    checkOutput("ferr_cleared", 32'(frame_error), 32'd0);

    $display("[TB] overflow on ninth byte");
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 8, 1'b1, -1, -1, 1'b0, 0, 1'b0);
    checkOutput("ovf_fifo_count", 32'(fifo_count), 32'd8);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) popExpect(8'(i), "ovf_pop");
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    pulseClear();
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);

    $display("[TB] push and pop together while full");
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 8, 1'b1, -1, -1, 1'b0, 0, (i == 9));
    checkOutput("fullpop_fifo_count", 32'(fifo_count), 32'd8);
    checkOutput("fullpop_overflow", 32'(overflow), 32'd0);
    for (int i = 2; i <= 9; i++) popExpect(8'(i), "fullpop_pop");

    $display("[TB] rx_enable dropped mid-frame");
    applyStimulus(8'hC3, 16, 1'b1, -1, 5, 1'b0, 0, 1'b0);
    checkOutput("abort_fifo_count", 32'(fifo_count), 32'd0);
    applyStimulus(8'h5A, 16, 1'b1, -1, -1, 1'b0, 0, 1'b0);
    popExpect(8'h5A, "abort_next_data");

    $display("[TB] reset mid-frame with three bytes queued");
    applyStimulus(8'h11, 8, 1'b1, -1, -1, 1'b0, 0, 1'b0);
    applyStimulus(8'h22, 8, 1'b1, -1, -1, 1'b0, 0, 1'b0);
    applyStimulus(8'h33, 8, 1'b1, -1, -1, 1'b0, 0, 1'b0);
    checkOutput("rstmid_pre_count", 32'(fifo_count), 32'd3);
    applyStimulus(8'h44, 8, 1'b1, -1, 3, 1'b1, 0, 1'b0);
    step(2);
    checkOutput("rstmid_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rstmid_data_valid", 32'(data_valid), 32'd0);

    $display("[TB] randomized frames with random reads");
    rnd_read_en = 1'b1;
    for (int n = 0; n < 14; n++) begin
      applyStimulus(8'($urandom), int'($urandom_range(0, 12)), ($urandom_range(0, 5) != 0),
                    -1, -1, 1'b0, int'($urandom_range(0, 20)), 1'b0);
      if ($urandom_range(0, 2) == 0) pulseClear();
    end
    rnd_read_en = 1'b0;
    step(2);
    for (int g = 0; g < 20 && mq.size() > 0; g++) begin
      data_read_man = 1'b1;
      step(1);
    end
    data_read_man = 1'b0;
    step(2);

`ifdef UART_RX_PARITY_EN
    $display("[TB] even parity");
    pulseClear();
    parity_mode = 2'b01;
    applyStimulus(8'h07, 16, 1'b1, 1, -1, 1'b0, 0, 1'b0);
    popExpect(8'h07, "par_good_data");
    applyStimulus(8'h07, 16, 1'b1, 0, -1, 1'b0, 0, 1'b0);
    checkOutput("par_bad_flag", 32'(parity_error), 32'd1);
    checkOutput("par_bad_fifo_count", 32'(fifo_count), 32'd0);
    parity_mode = 2'b00;
    step(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Serial receive front-end consumed by each UART device channel. It synchronises one uart_rx pin and recovers 8-bit frames (LSB first, 1 stop bit) using a programmable bit period. Received bytes go into a small FIFO, which the device's register interface pops. Frame and overflow errors are reported as sticky flags that drive the channel's rx status register and IRQ.

Parameters:
CLOCK_SCALE_WIDTH, 16, width of cycles_per_bit and of the internal bit-period counter
FIFO_DEPTH, 8, receive FIFO entries; must be a power of two, minimum 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx_enable  input  1  receiver enable; low forces the FSM to IDLE
cycles_per_bit  input  CLOCK_SCALE_WIDTH  clk cycles per bit; values below 4 are treated as 4
uart_rx  input  1  asynchronous serial input; idles high
data_out  output  8  FIFO head byte
data_valid  output  1  FIFO not empty
data_read  input  1  pop FIFO head this cycle
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
frame_error  output  1  sticky; stop bit sampled low
overflow  output  1  sticky; byte dropped because the FIFO was full
clear_errors  input  1  clears frame_error and overflow

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset state: FSM in IDLE, FIFO empty, data_out=0, data_valid=0, fifo_count=0, frame_error=0, overflow=0. The synchroniser flops reset to 1.
- uart_rx passes through a 2-flop synchroniser; all logic below uses the synchronised signal (rxs).
- Bit counter: counts 0..P-1, where P = max(cycles_per_bit, 4). cycles_per_bit is sampled at the start-bit edge and held for the whole frame.
- FSM states:
  - IDLE: on an rxs falling edge while rx_enable=1, go to START and clear the counter.
  - START: at count P/2 (integer division), sample rxs. If 1, treat as a glitch and return to IDLE with no flags set. If 0, clear the counter, set the bit index to 0 and go to DATA.
  - DATA: at each count P-1, shift rxs into bit[index] (LSB first). After index 7, go to STOP, or to PARITY when the optional feature is enabled.
  - STOP: at count P-1, sample rxs.
    - rxs=1: push the byte and go to IDLE.
    - rxs=0: set frame_error, discard the byte, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- Sampling points fall at mid-bit: the start bit is checked at P/2, and the data and stop bits are sampled a further P cycles apart from that point.
- Push latency: the byte appears on data_out with data_valid=1 on the cycle after the stop-bit sample. The FIFO is first-word-fall-through.
- Pop: data_read with data_valid=1 advances the head on the next edge. data_read with the FIFO empty is ignored.
- Push while full with no pop in the same cycle: the new byte is dropped, overflow is set, and FIFO contents are unchanged.
- Push and pop in the same cycle while full: both take effect, occupancy stays at FIFO_DEPTH, overflow is not set.
- Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
- Read and write pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- Sticky flags: clear_errors clears them on the next edge. If a set event and clear_errors occur in the same cycle, the set wins.
- rx_enable deasserted mid-frame: the FSM goes to IDLE on the next edge and the partial byte is discarded. FIFO contents and flags are preserved.
- rst mid-frame: everything returns to reset state and the FIFO is emptied.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds input parity_mode[1:0] (00 none, 01 even, 10 odd, 11 treated as none) and sticky output parity_error, cleared by clear_errors.
  - A PARITY state sits between DATA and STOP and samples one bit at count P-1.
  - On mismatch: set parity_error, then proceed to STOP; the byte is not pushed even if the stop bit is good.
- Undefined: neither port exists, the format is fixed at 8N1, and there is no PARITY state.

Decomposition:
- Package uart_rx_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - MIN_CYCLES_PER_BIT=4;
  - the parity_mode encodings.
- Sub-module uart_rx_fifo: parameterised-depth first-word-fall-through FIFO with push, pop, full, empty, count and head outputs; the drop-on-full policy is enforced there.
- Synchroniser and FSM stay in uart_rx_engine.

Test Plan:
- P=16, send 0xA5 (8N1): data_valid rises about 3 + 9.5×16 cycles after the start edge; data_out=0xA5, fifo_count=1. Pulse data_read → data_valid=0.
- P=16, rx low for 5 cycles then high: no push, FSM back in IDLE, no flags. Then cycles_per_bit=2: a 0x3C frame sent at P=4 is received as 0x3C (clamp check).
- 0x3C sent with the stop bit low, line held low 40 cycles, then high: frame_error=1, fifo_count=0, no 0x00 bytes pushed. Then clear_errors → frame_error=0.
- FIFO_DEPTH=8: send 9 bytes 0x01..0x09 with no reads → fifo_count=8, pops return 0x01..0x08, overflow=1. Repeat with data_read asserted in the 9th push cycle → no overflow, 0x09 retained.
- rx_enable dropped after 4 data bits: no push; the next full frame 0x5A is received correctly. Separately, rst mid-frame empties a FIFO holding 3 bytes.
- With UART_RX_PARITY_EN and parity_mode=01: send 0x07 with parity bit 1 → pushed. Send 0x07 with parity bit 0 → parity_error=1, not pushed.
